// File: rtl/biquad_coeff_pkg.sv
// Shared types and constants for the biquad coefficient loader.
package biquad_coeff_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_H,
      ST_HOLD_H,
      ST_WR_L,
      ST_HOLD_L,
      ST_SETTLE,
      ST_UPDATE
   } state_t;

   localparam int SETTLE_CYCLES  = 2;
   localparam int COEFF_BITS_DEF = 18;

   function automatic int hi_idx(input int k);
      return 2 * k;
   endfunction

   function automatic int lo_idx(input int k);
      return 2 * k + 1;
   endfunction

endpackage

// File: rtl/biquad8_coeff_loader.sv
// Shadow register file plus sequencer that shifts each stage's high/low
// B coefficients into a biquad bank and fires one broadcast update.
module biquad8_coeff_loader
   import biquad_coeff_pkg::*;
#(
   parameter int NBQ        = 4,
   parameter int COEFF_BITS = COEFF_BITS_DEF,
   parameter int ADR_BITS   = $clog2(2 * NBQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bus_wr_i,
   input  logic [ADR_BITS-1:0]   bus_adr_i,
   input  logic [COEFF_BITS-1:0] bus_dat_i,
   output logic [COEFF_BITS-1:0] bus_rdat_o,
   input  logic                  commit_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [COEFF_BITS-1:0] coeff_dat_o,
   output logic                  coeff_adr_o,
   output logic [NBQ-1:0]        coeff_wr_o,
   output logic                  coeff_update_o
);

   localparam int NENT = 2 * NBQ;
   localparam int IW   = $clog2(NENT);
   localparam int KW   = (NBQ > 1) ? $clog2(NBQ) : 1;
   localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int NENT_I = NENT;
   localparam logic [ADR_BITS:0] NENT_A = NENT_I[ADR_BITS:0];

   logic [COEFF_BITS-1:0] shadow [NENT];
   logic [COEFF_BITS-1:0] snap   [NENT];
   state_t                state;
   logic [KW-1:0]         k;
   logic [SW-1:0]         settle_cnt;
   logic                  pending;
   logic                  adr_ok;
   logic [IW-1:0]         adr_idx;
   logic                  start;

   assign adr_ok  = {1'b0, bus_adr_i} < NENT_A;
   assign adr_idx = bus_adr_i[IW-1:0];

   // A new sequence begins from IDLE on commit, or straight out of UPDATE
   // when a commit is pending or arrives in that very cycle.
   assign start = ((state == ST_IDLE) && commit_i) ||
                  ((state == ST_UPDATE) && (pending || commit_i));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NENT; i++) shadow[i] <= '0;
         bus_rdat_o <= '0;
      end else begin
         if (bus_wr_i && adr_ok) shadow[adr_idx] <= bus_dat_i;
         bus_rdat_o <= adr_ok ? shadow[adr_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NENT; i++) snap[i] <= '0;
         state          <= ST_IDLE;
         k              <= '0;
         settle_cnt     <= '0;
         pending        <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         coeff_dat_o    <= '0;
         coeff_adr_o    <= 1'b0;
         coeff_wr_o     <= '0;
         coeff_update_o <= 1'b0;
      end else begin
         done_o         <= 1'b0;
         coeff_update_o <= 1'b0;

         if (start)
            pending <= 1'b0;
         else if (commit_i && (state != ST_IDLE))
            pending <= 1'b1;

         if (start) begin
            // Snapshot and first data come from the shadow's pre-edge value.
            for (int i = 0; i < NENT; i++) snap[i] <= shadow[i];
            state       <= ST_WR_H;
            k           <= '0;
            busy_o      <= 1'b1;
            coeff_wr_o  <= NBQ'(1);
            coeff_adr_o <= 1'b0;
            coeff_dat_o <= shadow[IW'(hi_idx(0))];
         end else begin
            case (state)
               ST_WR_H: begin
                  state      <= ST_HOLD_H;
                  coeff_wr_o <= '0;
               end
               ST_HOLD_H: begin
                  state       <= ST_WR_L;
                  coeff_wr_o  <= NBQ'(1) << k;
                  coeff_adr_o <= 1'b1;
                  coeff_dat_o <= snap[IW'(lo_idx(int'(k)))];
               end
               ST_WR_L: begin
                  state      <= ST_HOLD_L;
                  coeff_wr_o <= '0;
               end
               ST_HOLD_L: begin
                  if (k == KW'(NBQ - 1)) begin
                     state       <= ST_SETTLE;
                     settle_cnt  <= '0;
                     coeff_adr_o <= 1'b0;
                     coeff_dat_o <= '0;
                  end else begin
                     state       <= ST_WR_H;
                     k           <= k + 1'b1;
                     coeff_wr_o  <= NBQ'(1) << (k + 1'b1);
                     coeff_adr_o <= 1'b0;
                     coeff_dat_o <= snap[IW'(hi_idx(int'(k) + 1))];
                  end
               end
               ST_SETTLE: begin
                  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                     state          <= ST_UPDATE;
                     coeff_update_o <= 1'b1;
                     done_o         <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
               ST_UPDATE: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
